// File: rtl/mux_pipe_pkg.sv
// Shared types and elaboration helpers for the pipelined N:1 selector.
package mux_pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL2 = 2'd2
    } mux_pipe_state_t;

    localparam int MIN_N_IN = 2;
    localparam int MAX_N_IN = 16;

    // True when a SEL_W-bit selector can address every one of n_in inputs.
    function automatic bit sel_w_legal(input int sel_w, input int n_in);
        return (64'(1) << sel_w) >= 64'(n_in);
    endfunction

endpackage

// File: rtl/mux_sel_n.sv
// Combinational N:1 pick; codes with no matching input return OOR_VAL.
module mux_sel_n #(
    parameter int               WIDTH   = 64,
    parameter int               N_IN    = 7,
    parameter int               SEL_W   = 4,
    parameter logic [WIDTH-1:0] OOR_VAL = '0
) (
    input  logic [N_IN-1:0][WIDTH-1:0] entradas,
    input  logic [SEL_W-1:0]           seletor,
    output logic [WIDTH-1:0]           pick
);

    always_comb begin
        pick = OOR_VAL;
        for (int i = 0; i < N_IN; i++) begin
            if (seletor == SEL_W'(i)) pick = entradas[i];
        end
    end

endmodule

// File: rtl/mux_pipe_sel.sv
// N:1 selector with a 2-entry skid buffer behind a valid/ready handshake.
// Define MUX_PIPE_OOR_CHECK_EN for the sticky sel_err flag and its assertion.
module mux_pipe_sel
    import mux_pipe_pkg::*;
#(
    parameter int               WIDTH   = 64,
    parameter int               N_IN    = 7,
    parameter int               SEL_W   = 4,
    parameter logic [WIDTH-1:0] OOR_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_IN-1:0][WIDTH-1:0] entradas,
    input  logic [SEL_W-1:0]           seletor,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       flush,
    output logic [WIDTH-1:0]           saida,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       sel_err
);

    localparam bit SEL_W_OK = sel_w_legal(SEL_W, N_IN);

    if (!SEL_W_OK) begin : g_bad_sel_w
        $error("mux_pipe_sel: SEL_W=%0d cannot address N_IN=%0d inputs", SEL_W, N_IN);
    end
    if (N_IN < MIN_N_IN || N_IN > MAX_N_IN) begin : g_bad_n_in
        $error("mux_pipe_sel: N_IN=%0d outside %0d..%0d", N_IN, MIN_N_IN, MAX_N_IN);
    end

    mux_pipe_state_t  state_q, state_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [WIDTH-1:0] pick;
    logic             accept, pop;

    mux_sel_n #(
        .WIDTH   (WIDTH),
        .N_IN    (N_IN),
        .SEL_W   (SEL_W),
        .OOR_VAL (OOR_VAL)
    ) u_sel (
        .entradas (entradas),
        .seletor  (seletor),
        .pick     (pick)
    );

    assign in_ready  = (state_q != FULL2);
    assign out_valid = (state_q != EMPTY);
    assign saida     = head_q;
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Flush wins over both handshakes; data regs keep stale contents.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    state_d = ONE;
                    head_d  = pick;
                end
                ONE: begin
                    if (accept && pop) begin
                        head_d = pick;
                    end else if (accept) begin
                        state_d = FULL2;
                        skid_d  = pick;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL2: if (pop) begin
                    state_d = ONE;
                    head_d  = skid_q;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

`ifdef MUX_PIPE_OOR_CHECK_EN
    localparam logic [SEL_W:0] N_IN_W = (SEL_W+1)'(N_IN);

    logic sel_err_q, sel_err_d;
    logic oor;

    assign oor = ({1'b0, seletor} >= N_IN_W);

    // Sticky until reset; flush deliberately leaves it alone.
    always_comb sel_err_d = sel_err_q | (accept & oor);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sel_err_q <= 1'b0;
        else       sel_err_q <= sel_err_d;
    end

    assign sel_err = sel_err_q;

    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            assert (!oor) else $warning("mux_pipe_sel: accepted out-of-range seletor %0d", seletor);
        end
    end
`else
    assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_pipe_sel.sv
// Self-checking bench for mux_pipe_sel: vector table plus scoreboard queue.
module tb_mux_pipe_sel;

    localparam int WIDTH = 64;
    localparam int N_IN  = 7;
    localparam int SEL_W = 4;
`ifdef MUX_PIPE_OOR_CHECK_EN
    localparam bit OOR_EN = 1'b1;
`else
    localparam bit OOR_EN = 1'b0;
`endif

    typedef struct {
        logic [SEL_W-1:0] sel;
        logic [WIDTH-1:0] exp;
    } vec_t;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [N_IN-1:0][WIDTH-1:0] entradas;
    logic [SEL_W-1:0]           seletor;
    logic                       in_valid;
    logic                       in_ready;
    logic                       flush;
    logic [WIDTH-1:0]           saida;
    logic                       out_valid;
    logic                       out_ready;
    logic                       sel_err;

    int compared   = 0;
    int mismatched = 0;
    logic [WIDTH-1:0] sb_q[$];
    vec_t vecs[10];

    mux_pipe_sel #(
        .WIDTH   (WIDTH),
        .N_IN    (N_IN),
        .SEL_W   (SEL_W),
        .OOR_VAL ('0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .entradas  (entradas),
        .seletor   (seletor),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .saida     (saida),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] model_pick(input logic [SEL_W-1:0] s);
        if (int'(s) < N_IN) return 64'h1000 + 64'(s);
        return '0;
    endfunction

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: pop/compare first, then push what the DUT accepts at the next edge.
    always @(negedge clk) begin
        if (reset || flush) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_output", saida, 'x);
                end else begin
                    check("sb_data", saida, sb_q.pop_front());
                end
            end
            if (in_valid && in_ready) sb_q.push_back(model_pick(seletor));
        end
    end

    task automatic drive(input logic v, input logic [SEL_W-1:0] s, input logic r);
        @(posedge clk);
        #1;
        in_valid  = v;
        seletor   = s;
        out_ready = r;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 50 && sb_q.size() != 0; k++) @(posedge clk);
        @(negedge clk);
        check("drain_empty", 64'(sb_q.size()), 64'd0);
        check("drain_out_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        vecs[0] = '{4'd0, 64'h1000};
        vecs[1] = '{4'd1, 64'h1001};
        vecs[2] = '{4'd2, 64'h1002};
        vecs[3] = '{4'd3, 64'h1003};
        vecs[4] = '{4'd4, 64'h1004};
        vecs[5] = '{4'd5, 64'h1005};
        vecs[6] = '{4'd6, 64'h1006};
        vecs[7] = '{4'd9, 64'h0};
        vecs[8] = '{4'd3, 64'h1003};
        vecs[9] = '{4'd15, 64'h0};

        for (int i = 0; i < N_IN; i++) entradas[i] = 64'h1000 + 64'(i);
        reset = 1'b1; in_valid = 1'b0; seletor = '0; flush = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_saida", saida, 64'd0);
        check("rst_sel_err", 64'(sel_err), 64'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Streaming, table-driven: every index, then out-of-range codes.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].sel, 1'b1);
            @(negedge clk);
            check("stream_in_ready", 64'(in_ready), 64'd1);
            if (i == 7) begin
                @(posedge clk); #1;
                check("oor_saida", saida, vecs[i].exp);
                check("oor_sel_err_set", 64'(sel_err), 64'(OOR_EN));
            end
        end
        drain();
        check("oor_sel_err_sticky", 64'(sel_err), 64'(OOR_EN));

        // Back-pressure: two accepts fill FULL2, head must hold.
        drive(1'b1, 4'd2, 1'b0);
        drive(1'b1, 4'd5, 1'b0);
        drive(1'b0, 4'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_hold_saida", saida, 64'h1002);
        end
        drive(1'b0, 4'd0, 1'b1);
        @(negedge clk);
        check("bp_first", saida, 64'h1002);
        @(negedge clk);
        check("bp_second", saida, 64'h1005);
        @(negedge clk);
        check("bp_empty", 64'(out_valid), 64'd0);
        check("bp_sb_empty", 64'(sb_q.size()), 64'd0);

        // Flush in FULL2 with a concurrent offer: nothing survives.
        drive(1'b1, 4'd1, 1'b0);
        drive(1'b1, 4'd4, 1'b0);
        @(posedge clk); #1;
        flush = 1'b1; in_valid = 1'b1; seletor = 4'd6; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        repeat (3) @(negedge clk);
        check("flush_no_delivery", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-stream, checked before the next edge.
        drive(1'b1, 4'd0, 1'b0);
        drive(1'b1, 4'd1, 1'b0);
        drive(1'b0, 4'd0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_saida", saida, 64'd0);
        check("mid_rst_sel_err", 64'(sel_err), 64'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Random traffic with random back-pressure.
        for (int k = 0; k < 300; k++) begin
            drive(1'($urandom_range(0, 1)), SEL_W'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
